fm_spy_buffer: RTL and testbench
================================

# fm_spy_buffer

Single-channel spy buffer for the FM block. It records a data stream into a circular RAM and stops recording on `freeze`. It replays the stored contents on `playback_mode` and clears its RAM on `init_spy_mem`. It consumes one bit of each per-buffer control vector (`freeze`, `playback_mode`, `sb_reset`, `init_spy_mem`) produced by the FM spy-buffer control stage, and exposes a random-access readout port for the AXI register/memory interface.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of recorded word.
- `ADDR_WIDTH`, 10: RAM depth is 2^ADDR_WIDTH words.
- `PB_MODE_WIDTH`, 2: playback mode width.

Ports:
- Clock and reset (already decided): one clock, `axi_clk`; reset is `axi_reset`, synchronous and active-high.
- `axi_clk`  in  1  single clock for all logic and both RAM ports.
- `axi_reset`  in  1  synchronous, active-high reset.
- `sb_reset`  in  1  per-buffer soft reset; same effect as `axi_reset`; RAM contents untouched.
- `freeze`  in  1  level; high stops recording.
- `playback_mode`  in  PB_MODE_WIDTH  0=record, 1=play once, 2=play loop, 3=treated as 0.
- `init_spy_mem`  in  1  level; a rising edge starts RAM clear.
- `data_in`  in  DATA_WIDTH  live data.
- `data_in_valid`  in  1  qualifies `data_in`.
- `data_out`  out  DATA_WIDTH  passthrough or playback data.
- `data_out_valid`  out  1  qualifies `data_out`.
- `rd_en`  in  1  readout request.
- `rd_addr`  in  ADDR_WIDTH  readout address.
- `rd_data`  out  DATA_WIDTH  readout data.
- `rd_valid`  out  1  qualifies `rd_data`.
- `wr_ptr`  out  ADDR_WIDTH  next write address.
- `wrapped`  out  1  buffer has wrapped at least once since the last reset.
- `frozen`  out  1  state is FROZEN or PLAYBACK.
- `init_busy`  out  1  state is INIT.

## Operation
RAM organisation:
- Simple dual-port RAM.
- Port A is write/playback-read; these are mutually exclusive by state.
- Port B is readout only.

States:
- RECORD
  - Each `data_in_valid` writes `mem[wr_ptr]`, then `wr_ptr++` modulo 2^ADDR_WIDTH.
  - The increment from max to 0 sets `wrapped`; it stays set until reset.
  - `data_out`/`data_out_valid` = `data_in`/`data_in_valid`, registered.
  - `freeze`=1 → FROZEN. The word presented in that cycle is passed through but not written; freeze has priority.
  - `playback_mode` is ignored in this state.
- FROZEN
  - No writes; `data_out_valid`=0; live data is discarded.
  - `playback_mode`∈{1,2} and `armed` → PLAYBACK.
  - `freeze`=0 and `playback_mode`=0 → RECORD. `wr_ptr` and `wrapped` are retained, so recording continues where it stopped.
- PLAYBACK
  - Start address is `wrapped ? wr_ptr : 0`.
  - Word count N is `wrapped ? 2^ADDR_WIDTH : wr_ptr`.
  - One read is issued per cycle, address incrementing modulo depth, producing N consecutive `data_out_valid` words in oldest-first order.
  - Mode 1: after word N → FROZEN and `armed` is cleared. `armed` re-sets when `playback_mode`=0 is seen.
  - Mode 2: after word N, restart at the start address with no gap cycle.
  - `playback_mode` becomes 0 mid-stream: stop issuing reads; words already in flight (≤2) are still output; → FROZEN.
  - N=0 (empty buffer): no output; → FROZEN; `armed` cleared.
  - `freeze` is ignored while in PLAYBACK.
- INIT
  - Entered from any state on a rising edge of `init_spy_mem`. A rising edge while already in INIT is ignored.
  - Writes 0 to addresses 0 … 2^ADDR_WIDTH−1, one per cycle.
  - `wr_ptr`←0 and `wrapped`←0 on entry.
  - On completion → FROZEN if `freeze`=1, else RECORD.
  - Playback data in flight is dropped.

Readout:
- `rd_en` is honoured in every state, including INIT, where it reads current contents.

Reset (`axi_reset` or `sb_reset`):
- State goes to RECORD.
- `wr_ptr`=0, `wrapped`=0, `armed`=1.
- `data_out`=0, `data_out_valid`=0, `rd_data`=0, `rd_valid`=0.
- The `init_spy_mem` edge detector is loaded with the current input level, so a level held high through reset does not trigger INIT.
- Reset takes priority over every other event, including mid-INIT and mid-PLAYBACK.

## Timing
- RECORD passthrough: `data_out` follows `data_in` by 1 cycle.
- Freeze: `freeze` high in cycle t → no write in t. `frozen`=1 from t+1.
- Playback: state becomes PLAYBACK at cycle t and the first read is issued in t. The first `data_out_valid` is at t+2 (registered RAM output plus output register), and the stream is continuous thereafter.
- INIT: an `init_spy_mem` rising edge sampled at t → `init_busy`=1 from t+1 for exactly 2^ADDR_WIDTH cycles.
- Readout: `rd_en` at t → `rd_data`/`rd_valid` at t+1. A same-address write in t returns old data (read-first).

## Test plan
- Reset, then 5 valid words 0xA0–0xA4; `freeze`=1; `playback_mode`=1 → `data_out` 0xA0…0xA4 exactly once starting 2 cycles after entry; `wr_ptr`=5; `frozen`=1.
- ADDR_WIDTH=3: write 10 words 1…10; freeze; play once → output 3,4,…,10 (8 words); `wrapped`=1.
- Play loop on 3 stored words, then drop mode to 0 after 7 output words → output 1,2,3,1,2,3,1 plus ≤2 in-flight words; returns to FROZEN.
- `init_spy_mem` edge mid-PLAYBACK → `init_busy` for 2^ADDR_WIDTH cycles; readout of every address = 0; `wr_ptr`=0.
- `freeze` asserted coincident with `data_in_valid` → that word is passed through but not stored; `wr_ptr` unchanged.
- `sb_reset` mid-INIT → RECORD next cycle; `init_busy`=0; `wr_ptr`=0; a later `playback_mode`=1 after freeze with 0 words written → no output.

Source files
------------

// File: rtl/fm_spy_buffer.sv
// Single-channel FM spy buffer: circular record RAM, freeze, playback and RAM clear.
// Latency: passthrough 1 cycle, playback first word 2 cycles after entry, readout 1 cycle.
// Backpressure: none; data_out is a valid-only stream and live data is dropped when not recording.
module fm_spy_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int PB_MODE_WIDTH = 2
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset,
    input  logic                     sb_reset,
    input  logic                     freeze,
    input  logic [PB_MODE_WIDTH-1:0] playback_mode,
    input  logic                     init_spy_mem,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_out_valid,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic [ADDR_WIDTH-1:0]    wr_ptr,
    output logic                     wrapped,
    output logic                     frozen,
    output logic                     init_busy
);

    typedef enum logic [1:0] {
        ST_RECORD   = 2'd0,
        ST_FROZEN   = 2'd1,
        ST_PLAYBACK = 2'd2,
        ST_INIT     = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                    wrapped_q, wrapped_d;
    logic                    armed_q, armed_d;
    logic                    init_prev_q, init_prev_d;
    logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
    logic [ADDR_WIDTH-1:0]   pb_addr_q, pb_addr_d;
    logic [ADDR_WIDTH-1:0]   pb_start_q, pb_start_d;
    logic [ADDR_WIDTH:0]     pb_cnt_q, pb_cnt_d;
    logic                    pb_pipe_vld_q, pb_pipe_vld_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_out_vld_q, data_out_vld_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [DATA_WIDTH-1:0]   pa_rdat_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic                    rst;
    logic                    init_rise;
    logic                    pb_play;
    logic                    pb_loop;
    logic [ADDR_WIDTH:0]     pb_total;
    logic [ADDR_WIDTH:0]     pb_cnt_inc;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   pa_addr;
    logic [DATA_WIDTH-1:0]   mem_wdat;

    assign rst        = axi_reset | sb_reset;
    assign init_rise  = init_spy_mem & ~init_prev_q;
    assign pb_loop    = (playback_mode == PB_MODE_WIDTH'(2));
    assign pb_play    = (playback_mode == PB_MODE_WIDTH'(1)) | pb_loop;
    // Once wrapped the whole RAM is valid history, oldest word sits at wr_ptr.
    assign pb_total   = wrapped_q ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, wr_ptr_q};
    assign pb_cnt_inc = pb_cnt_q + CNT_ONE;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        wrapped_d      = wrapped_q;
        armed_d        = armed_q;
        init_prev_d    = init_spy_mem;
        init_addr_d    = init_addr_q;
        pb_addr_d      = pb_addr_q;
        pb_start_d     = pb_start_q;
        pb_cnt_d       = pb_cnt_q;
        pb_pipe_vld_d  = 1'b0;
        data_out_d     = data_out_q;
        data_out_vld_d = 1'b0;
        rd_valid_d     = rd_en;
        mem_we         = 1'b0;
        pa_addr        = wr_ptr_q;
        mem_wdat       = data_in;

        if (!pb_play) begin
            armed_d = 1'b1;
        end

        if (state_q == ST_RECORD) begin
            data_out_d     = data_in;
            data_out_vld_d = data_in_valid;
        end else if (pb_pipe_vld_q) begin
            data_out_d     = pa_rdat_q;
            data_out_vld_d = 1'b1;
        end

        case (state_q)
            ST_RECORD: begin
                if (freeze) begin
                    state_d = ST_FROZEN;
                end else if (data_in_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_ONE;
                    if (wr_ptr_q == ADDR_MAX) begin
                        wrapped_d = 1'b1;
                    end
                end
            end
            ST_FROZEN: begin
                if (pb_play && armed_q) begin
                    state_d    = ST_PLAYBACK;
                    pb_start_d = wrapped_q ? wr_ptr_q : '0;
                    pb_addr_d  = wrapped_q ? wr_ptr_q : '0;
                    pb_cnt_d   = '0;
                end else if (!freeze && !pb_play) begin
                    state_d = ST_RECORD;
                end
            end
            ST_PLAYBACK: begin
                pa_addr = pb_addr_q;
                if (!pb_play) begin
                    state_d = ST_FROZEN;
                end else if (pb_total == '0) begin
                    state_d = ST_FROZEN;
                    armed_d = 1'b0;
                end else begin
                    pb_pipe_vld_d = 1'b1;
                    if (pb_cnt_inc == pb_total) begin
                        if (pb_loop) begin
                            pb_addr_d = pb_start_q;
                            pb_cnt_d  = '0;
                        end else begin
                            state_d = ST_FROZEN;
                            armed_d = 1'b0;
                        end
                    end else begin
                        pb_addr_d = pb_addr_q + ADDR_ONE;
                        pb_cnt_d  = pb_cnt_inc;
                    end
                end
            end
            ST_INIT: begin
                mem_we   = 1'b1;
                pa_addr  = init_addr_q;
                mem_wdat = '0;
                if (init_addr_q == ADDR_MAX) begin
                    state_d = freeze ? ST_FROZEN : ST_RECORD;
                end else begin
                    init_addr_d = init_addr_q + ADDR_ONE;
                end
            end
            default: begin
                state_d = ST_RECORD;
            end
        endcase

        // A clear request overrides whatever the current state decided this cycle.
        if (init_rise && state_q != ST_INIT) begin
            state_d        = ST_INIT;
            init_addr_d    = '0;
            wr_ptr_d       = '0;
            wrapped_d      = 1'b0;
            mem_we         = 1'b0;
            pb_pipe_vld_d  = 1'b0;
            data_out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state_q        <= ST_RECORD;
            wr_ptr_q       <= '0;
            wrapped_q      <= 1'b0;
            armed_q        <= 1'b1;
            init_prev_q    <= init_spy_mem;
            init_addr_q    <= '0;
            pb_addr_q      <= '0;
            pb_start_q     <= '0;
            pb_cnt_q       <= '0;
            pb_pipe_vld_q  <= 1'b0;
            data_out_q     <= '0;
            data_out_vld_q <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            wrapped_q      <= wrapped_d;
            armed_q        <= armed_d;
            init_prev_q    <= init_prev_d;
            init_addr_q    <= init_addr_d;
            pb_addr_q      <= pb_addr_d;
            pb_start_q     <= pb_start_d;
            pb_cnt_q       <= pb_cnt_d;
            pb_pipe_vld_q  <= pb_pipe_vld_d;
            data_out_q     <= data_out_d;
            data_out_vld_q <= data_out_vld_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

    // RAM: port A write/playback read, port B readout; both read-first.
    always_ff @(posedge axi_clk) begin
        if (mem_we && !rst) begin
            mem[pa_addr] <= mem_wdat;
        end
        pa_rdat_q <= mem[pa_addr];
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_vld_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign wr_ptr         = wr_ptr_q;
    assign wrapped        = wrapped_q;
    assign frozen         = (state_q == ST_FROZEN) || (state_q == ST_PLAYBACK);
    assign init_busy      = (state_q == ST_INIT);

endmodule

// File: tb/tb_fm_spy_buffer.sv
// Directed bench for fm_spy_buffer with an 8-deep RAM.
module tb_fm_spy_buffer;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          axi_clk = 1'b0;
    logic          axi_reset;
    logic          sb_reset;
    logic          freeze;
    logic [1:0]    playback_mode;
    logic          init_spy_mem;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] wr_ptr;
    logic          wrapped;
    logic          frozen;
    logic          init_busy;

    fm_spy_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PB_MODE_WIDTH(2)) dut (
        .axi_clk        (axi_clk),
        .axi_reset      (axi_reset),
        .sb_reset       (sb_reset),
        .freeze         (freeze),
        .playback_mode  (playback_mode),
        .init_spy_mem   (init_spy_mem),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .wr_ptr         (wr_ptr),
        .wrapped        (wrapped),
        .frozen         (frozen),
        .init_busy      (init_busy)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct packed {
        logic          frz;
        logic [1:0]    mode;
        logic          dvld;
        logic [31:0]   din;
        logic          exp_vld;
        logic [31:0]   exp_dout;
        logic [2:0]    exp_wp;
        logic          exp_frozen;
    } vec_t;

    vec_t          tbl [8];
    int            total = 0;
    int            bad   = 0;
    logic          cap_v [32];
    logic [31:0]   cap_d [32];
    logic [31:0]   q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        axi_reset = 1'b1;
        step();
        step();
        axi_reset = 1'b0;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cap_v[i] = data_out_valid;
            cap_d[i] = data_out;
        end
    endtask

    // Edge k (1-based) after the mode change should carry word base+(k-first) for first<=k<first+cnt.
    task automatic check_stream(input string nm, input int n, input int first, input int cnt,
                                input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            logic ev;
            ev = (i + 1 >= first) && (i + 1 < first + cnt);
            chk({nm, "_vld"}, 32'(cap_v[i]), 32'(ev));
            if (ev) chk({nm, "_dat"}, cap_d[i], base + 32'(i + 1 - first));
        end
    endtask

    initial begin
        axi_reset = 1'b1; sb_reset = 1'b0; freeze = 1'b0; playback_mode = 2'd0;
        init_spy_mem = 1'b0; data_in = '0; data_in_valid = 1'b0; rd_en = 1'b0; rd_addr = '0;

        //            frz  mode  dvld  din     evld  edout   ewp   efrz
        tbl[0] = '{1'b0, 2'd0, 1'b1, 32'hA0, 1'b1, 32'hA0, 3'd1, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 32'hA1, 1'b1, 32'hA1, 3'd2, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 32'hFF, 1'b0, 32'hFF, 3'd2, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 32'hA2, 1'b1, 32'hA2, 3'd3, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 32'hA3, 1'b1, 32'hA3, 3'd4, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 32'hA4, 1'b1, 32'hA4, 3'd5, 1'b0};
        tbl[6] = '{1'b1, 2'd0, 1'b1, 32'hB7, 1'b1, 32'hB7, 3'd5, 1'b1};
        tbl[7] = '{1'b1, 2'd0, 1'b1, 32'hB8, 1'b0, 32'hB7, 3'd5, 1'b1};

        step();
        step();
        chk("rst_dout",   data_out, 32'h0);
        chk("rst_vld",    32'(data_out_valid), 32'h0);
        chk("rst_rdata",  rd_data, 32'h0);
        chk("rst_rvld",   32'(rd_valid), 32'h0);
        chk("rst_wp",     32'(wr_ptr), 32'h0);
        chk("rst_wrap",   32'(wrapped), 32'h0);
        chk("rst_frozen", 32'(frozen), 32'h0);
        chk("rst_ibusy",  32'(init_busy), 32'h0);
        axi_reset = 1'b0;

        // Record, then freeze coincident with a valid word.
        for (int i = 0; i < 8; i++) begin
            freeze = tbl[i].frz; playback_mode = tbl[i].mode;
            data_in_valid = tbl[i].dvld; data_in = tbl[i].din;
            step();
            chk($sformatf("vec%0d_vld", i), 32'(data_out_valid), 32'(tbl[i].exp_vld));
            chk($sformatf("vec%0d_dout", i), data_out, tbl[i].exp_dout);
            chk($sformatf("vec%0d_wp", i), 32'(wr_ptr), 32'(tbl[i].exp_wp));
            chk($sformatf("vec%0d_frz", i), 32'(frozen), 32'(tbl[i].exp_frozen));
            chk($sformatf("vec%0d_wrap", i), 32'(wrapped), 32'h0);
        end
        data_in_valid = 1'b0;

        // Play once: A0..A4 at edges 3..7, nothing after.
        playback_mode = 2'd1;
        collect(14);
        check_stream("once", 14, 3, 5, 32'hA0);
        chk("once_wp", 32'(wr_ptr), 32'd5);
        chk("once_frozen", 32'(frozen), 32'd1);

        // Wrap: 10 words into 8 entries, oldest-first playback is 3..10.
        playback_mode = 2'd0; freeze = 1'b0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            data_in = 32'(i); data_in_valid = 1'b1;
            step();
        end
        data_in_valid = 1'b0;
        chk("wrap_wp", 32'(wr_ptr), 32'd2);
        chk("wrap_flag", 32'(wrapped), 32'd1);
        freeze = 1'b1;
        step();
        playback_mode = 2'd1;
        collect(14);
        check_stream("wrap", 14, 3, 8, 32'd3);
        chk("wrap_flag2", 32'(wrapped), 32'd1);

        // Loop on 3 words, drop mode after the 7th output word.
        playback_mode = 2'd0; freeze = 1'b0;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            data_in = 32'(i); data_in_valid = 1'b1;
            step();
        end
        data_in_valid = 1'b0;
        freeze = 1'b1;
        step();
        q.delete();
        playback_mode = 2'd2;
        for (int i = 0; i < 30; i++) begin
            step();
            if (data_out_valid) q.push_back(data_out);
            if (q.size() == 7 && playback_mode == 2'd2) playback_mode = 2'd0;
        end
        chk("loop_count_ok", 32'(q.size() >= 7 && q.size() <= 9), 32'd1);
        for (int i = 0; i < q.size(); i++) chk($sformatf("loop_w%0d", i), q[i], 32'((i % 3) + 1));
        chk("loop_frozen", 32'(frozen), 32'd1);

        // Readout of live contents.
        rd_en = 1'b1; rd_addr = 3'd1;
        step();
        chk("rd_a1_vld", 32'(rd_valid), 32'd1);
        chk("rd_a1", rd_data, 32'd2);
        rd_addr = 3'd5;
        step();
        chk("rd_a5", rd_data, 32'd6);
        rd_en = 1'b0;
        step();
        chk("rd_idle_vld", 32'(rd_valid), 32'd0);

        // Clear request in the middle of a loop playback.
        playback_mode = 2'd2;
        step(); step(); step(); step();
        init_spy_mem = 1'b1; playback_mode = 2'd0;
        step();
        begin
            int busy_cnt;
            chk("init_busy_1st", 32'(init_busy), 32'd1);
            chk("init_dout_drop", 32'(data_out_valid), 32'd0);
            chk("init_wp", 32'(wr_ptr), 32'd0);
            busy_cnt = 1;
            for (int i = 0; i < 20; i++) begin
                step();
                if (!init_busy) break;
                busy_cnt++;
            end
            chk("init_busy_len", 32'(busy_cnt), 32'd8);
        end
        chk("init_done_frozen", 32'(frozen), 32'd1);
        chk("init_done_wrap", 32'(wrapped), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            step();
            chk($sformatf("clr_a%0d", a), rd_data, 32'h0);
        end
        rd_en = 1'b0;

        // Soft reset while clearing; init level held high must not retrigger.
        init_spy_mem = 1'b0; freeze = 1'b0;
        step();
        init_spy_mem = 1'b1;
        step();
        chk("sbr_init_on", 32'(init_busy), 32'd1);
        step(); step();
        sb_reset = 1'b1;
        step();
        chk("sbr_ibusy", 32'(init_busy), 32'd0);
        chk("sbr_frozen", 32'(frozen), 32'd0);
        chk("sbr_wp", 32'(wr_ptr), 32'd0);
        sb_reset = 1'b0;
        step();
        chk("sbr_no_retrig", 32'(init_busy), 32'd0);
        freeze = 1'b1;
        step();
        playback_mode = 2'd1;
        collect(10);
        check_stream("empty", 10, 3, 0, 32'd0);
        chk("empty_frozen", 32'(frozen), 32'd1);

        // Read-first on a same-address write.
        playback_mode = 2'd0; freeze = 1'b0;
        step();
        data_in = 32'h55; data_in_valid = 1'b1; rd_en = 1'b1; rd_addr = 3'd0;
        step();
        chk("rf_old", rd_data, 32'h0);
        chk("rf_pass", data_out, 32'h55);
        data_in_valid = 1'b0;
        step();
        chk("rf_new", rd_data, 32'h55);
        chk("rf_wp", 32'(wr_ptr), 32'd1);
        rd_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
